// File: rtl/cmv300_sensor_emu.sv
// CMV300 sensor emulator: transmit side of the CMV300 parallel pixel interface.
// Optional frame stamp in the first four pixels of row 0: define CMV_EMU_FRAME_STAMP_EN.
module cmv300_sensor_emu #(
    parameter int H_PIXELS   = 648,
    parameter int V_LINES    = 488,
    parameter int H_BLANK    = 16,
    parameter int FOT_CYCLES = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sys_res,
    input  logic       i_frame_req,
    input  logic [1:0] i_pattern,
    output logic       o_clk_out,
    output logic [9:0] o_data,
    output logic       o_lval,
    output logic       o_dval,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int COL_W = $clog2(H_PIXELS + 1);
    localparam int ROW_W = $clog2(V_LINES + 1);
    localparam int FOT_W = $clog2(FOT_CYCLES + 1);
    localparam int BLK_W = (H_BLANK > 0) ? $clog2(H_BLANK + 1) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_LINES - 1);
    localparam logic [FOT_W-1:0] FOT_LAST = FOT_W'(FOT_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(H_BLANK - 1);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_FOT    = 3'd2;
    localparam logic [2:0] S_LINE   = 3'd3;
    localparam logic [2:0] S_HBLANK = 3'd4;
    localparam logic [2:0] S_EOF    = 3'd5;

    logic [2:0]       state_reg, state_next;
    logic             pending_reg, pending_next;
    logic [1:0]       pattern_reg, pattern_next;
    logic [FOT_W-1:0] fot_cnt_reg, fot_cnt_next;
    logic [BLK_W-1:0] blank_cnt_reg, blank_cnt_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [9:0]       data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             clk_out_reg;
    logic             tick;
    logic [9:0]       pixel;
    logic [31:0]      row_ext, col_ext, sum_ext;

`ifdef CMV_EMU_FRAME_STAMP_EN
    logic [31:0] frame_cnt_reg, frame_cnt_next;
    logic [7:0]  stamp_bytes [4];

    // Byte 0 is the most significant, so col 0 carries the MSB.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stamp
            assign stamp_bytes[gi] = frame_cnt_reg[31-8*gi -: 8];
        end
    endgenerate
`endif

    // A tick is the i_clk edge on which o_clk_out rises.
    assign tick = ~clk_out_reg;

    always_comb begin
        row_ext = 32'(row_reg);
        col_ext = 32'(col_reg);
        sum_ext = row_ext + col_ext;
        case (pattern_reg)
            2'd0:    pixel = sum_ext[9:0];
            2'd1:    pixel = col_ext[9:0];
            2'd2:    pixel = row_ext[9:0];
            default: pixel = col_reg[0] ? 10'h155 : 10'h2AA;
        endcase
`ifdef CMV_EMU_FRAME_STAMP_EN
        if (row_reg == '0 && col_reg < COL_W'(4)) begin
            pixel = {stamp_bytes[col_reg[1:0]], 2'b00};
        end
`endif
    end

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        pattern_next   = pattern_reg;
        fot_cnt_next   = fot_cnt_reg;
        blank_cnt_next = blank_cnt_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
`ifdef CMV_EMU_FRAME_STAMP_EN
        frame_cnt_next = frame_cnt_reg;
`endif

        // One-deep request latch; acceptance and setting are mutually exclusive.
        if (i_frame_req && state_reg != S_RESET && !pending_reg) begin
            pending_next = 1'b1;
        end

        if (tick) begin
            valid_next = 1'b0;
            data_next  = '0;
            case (state_reg)
                S_RESET: state_next = S_IDLE;
                S_IDLE: begin
                    if (pending_reg) begin
                        pending_next = 1'b0;
                        pattern_next = i_pattern;
                        busy_next    = 1'b1;
                        fot_cnt_next = '0;
                        state_next   = S_FOT;
                    end
                end
                S_FOT: begin
                    if (fot_cnt_reg == FOT_LAST) begin
                        row_next   = '0;
                        col_next   = '0;
                        state_next = S_LINE;
                    end else begin
                        fot_cnt_next = fot_cnt_reg + FOT_W'(1);
                    end
                end
                S_LINE: begin
                    valid_next = 1'b1;
                    data_next  = pixel;
                    col_next   = col_reg + COL_W'(1);
                    if (col_reg == COL_LAST) begin
                        if (row_reg == ROW_LAST) begin
                            state_next = S_EOF;
                        end else if (H_BLANK == 0) begin
                            row_next = row_reg + ROW_W'(1);
                            col_next = '0;
                        end else begin
                            blank_cnt_next = '0;
                            state_next     = S_HBLANK;
                        end
                    end
                end
                S_HBLANK: begin
                    if (blank_cnt_reg == BLK_LAST) begin
                        row_next   = row_reg + ROW_W'(1);
                        col_next   = '0;
                        state_next = S_LINE;
                    end else begin
                        blank_cnt_next = blank_cnt_reg + BLK_W'(1);
                    end
                end
                S_EOF: begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = S_IDLE;
`ifdef CMV_EMU_FRAME_STAMP_EN
                    frame_cnt_next = frame_cnt_reg + 32'd1;
`endif
                end
                default: state_next = S_RESET;
            endcase
        end

        // Sensor reset aborts on any i_clk, not only on ticks.
        if (!i_sys_res) begin
            state_next     = S_RESET;
            pending_next   = 1'b0;
            fot_cnt_next   = '0;
            blank_cnt_next = '0;
            row_next       = '0;
            col_next       = '0;
            data_next      = '0;
            valid_next     = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b0;
`ifdef CMV_EMU_FRAME_STAMP_EN
            frame_cnt_next = '0;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= S_RESET;
            pending_reg   <= 1'b0;
            pattern_reg   <= '0;
            fot_cnt_reg   <= '0;
            blank_cnt_reg <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            clk_out_reg   <= 1'b0;
`ifdef CMV_EMU_FRAME_STAMP_EN
            frame_cnt_reg <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            pattern_reg   <= pattern_next;
            fot_cnt_reg   <= fot_cnt_next;
            blank_cnt_reg <= blank_cnt_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            clk_out_reg   <= ~clk_out_reg;
`ifdef CMV_EMU_FRAME_STAMP_EN
            frame_cnt_reg <= frame_cnt_next;
`endif
        end
    end

    assign o_clk_out    = clk_out_reg;
    assign o_data       = data_reg;
    assign o_lval       = valid_reg;
    assign o_dval       = valid_reg;
    assign o_busy       = busy_reg;
    assign o_frame_done = done_reg;

endmodule

// File: tb/tb_cmv300_sensor_emu.sv
// Randomized bench for cmv300_sensor_emu against a tick-offset frame model.
// Compile with CMV_EMU_FRAME_STAMP_EN defined to also check the frame stamp.
module tb_cmv300_sensor_emu;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int HB  = 2;
    localparam int FOT = 3;
    // Ticks from the accepting tick to the frame-end tick.
    localparam int END_K = FOT + 1 + V * H + (V - 1) * HB;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_sys_res = 1'b1;
    logic       i_frame_req = 1'b0;
    logic [1:0] i_pattern = 2'd0;
    logic       o_clk_out;
    logic [9:0] o_data;
    logic       o_lval;
    logic       o_dval;
    logic       o_busy;
    logic       o_frame_done;

    cmv300_sensor_emu #(
        .H_PIXELS(H), .V_LINES(V), .H_BLANK(HB), .FOT_CYCLES(FOT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sys_res(i_sys_res),
        .i_frame_req(i_frame_req), .i_pattern(i_pattern),
        .o_clk_out(o_clk_out), .o_data(o_data), .o_lval(o_lval),
        .o_dval(o_dval), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] pix(input int pat, input int row, input int col,
                                       input int unsigned frames);
        int unsigned v;
        case (pat)
            0:       v = (row + col) % 1024;
            1:       v = col % 1024;
            2:       v = row % 1024;
            default: v = (col % 2 == 0) ? 32'h2AA : 32'h155;
        endcase
`ifdef CMV_EMU_FRAME_STAMP_EN
        if (row == 0 && col < 4) v = ((frames >> (8 * (3 - col))) & 32'hFF) << 2;
`endif
        return v[9:0];
    endfunction

    // Model: 0 = sensor reset, 1 = idle, 2 = frame running (m_k ticks since acceptance).
    int          m_state = 0;
    bit          m_pending = 0;
    int          m_k = 0;
    int          m_pat = 0;
    logic        m_clk = 0;
    logic        m_lval = 0;
    logic        m_busy = 0;
    logic        m_done = 0;
    logic [9:0]  m_data = '0;
    int unsigned m_frames = 0;
    int          total_frames = 0;
    int          dut_done_cnt = 0;

    initial begin
        int old_state;
        bit old_pend;
        bit tick;
        bit accepted;
        int off;
        int row;
        int pos;
        forever begin
            @(posedge i_clk);
            if (!i_rst_n) begin
                m_state = 0; m_pending = 0; m_k = 0; m_clk = 0;
                m_lval = 0; m_busy = 0; m_done = 0; m_data = '0; m_frames = 0;
            end else begin
                tick      = !m_clk;
                old_state = m_state;
                old_pend  = m_pending;
                m_clk     = ~m_clk;
                m_done    = 0;
                if (!i_sys_res) begin
                    m_state = 0; m_pending = 0; m_lval = 0; m_data = '0;
                    m_busy = 0; m_frames = 0;
                end else begin
                    accepted = 0;
                    if (tick) begin
                        if (old_state == 0) begin
                            m_state = 1;
                        end else if (old_state == 1) begin
                            if (old_pend) begin
                                accepted = 1; m_pat = int'(i_pattern); m_k = 0;
                                m_busy = 1; m_state = 2; m_lval = 0; m_data = '0;
                            end
                        end else begin
                            m_k++;
                            m_lval = 0;
                            m_data = '0;
                            if (m_k == END_K) begin
                                m_busy = 0; m_done = 1; m_state = 1;
                                total_frames++;
                                $display("frame %0d done pattern=%0d stamp=%0d t=%0t",
                                         total_frames, m_pat, m_frames, $time);
                                m_frames++;
                            end else if (m_k > FOT) begin
                                off = m_k - FOT - 1;
                                row = off / (H + HB);
                                pos = off % (H + HB);
                                if (pos < H) begin
                                    m_lval = 1;
                                    m_data = pix(m_pat, row, pos, m_frames);
                                end
                            end
                        end
                    end
                    if (accepted) m_pending = 0;
                    else if (i_frame_req && old_state != 0 && !old_pend) m_pending = 1;
                end
            end
            #1;
            if (o_frame_done === 1'b1) dut_done_cnt++;
            chk("clk_out", o_clk_out, m_clk);
            chk("data", o_data, m_data);
            chk("lval", o_lval, m_lval);
            chk("dval", o_dval, m_lval);
            chk("busy", o_busy, m_busy);
            chk("frame_done", o_frame_done, m_done);
        end
    end

    initial begin
        int sres_cnt;
        int rate;
        bit seen;
        sres_cnt = 0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);

        // Single one-cycle request, column-ramp pattern, then let it finish.
        i_pattern = 2'd1;
        i_frame_req = 1'b1;
        @(negedge i_clk);
        i_frame_req = 1'b0;
        repeat (120) @(negedge i_clk);

        // Async reset mid-line must clear outputs without a clock edge.
        seen = 0;
        i_frame_req = 1'b1;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge i_clk);
            if (o_lval === 1'b1) seen = 1;
        end
        i_frame_req = 1'b0;
        chk("lval_seen", 32'(seen), 32'd1);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_lval", o_lval, 1'b0);
        chk("async_data", o_data, 10'd0);
        chk("async_busy", o_busy, 1'b0);
        chk("async_clk_out", o_clk_out, 1'b0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Random requests, patterns and sensor-reset pulses.
        for (int c = 0; c < 15000 && n_mis < 20; c++) begin
            @(negedge i_clk);
            rate = ((c / 2500) % 2 == 1) ? 25 : 250;
            i_frame_req = ($urandom_range(rate - 1) == 0);
            if ($urandom_range(7) == 0) i_pattern = 2'($urandom_range(3));
            if (sres_cnt == 0 && $urandom_range(1499) == 0) sres_cnt = $urandom_range(6, 1);
            i_sys_res = (sres_cnt == 0);
            if (sres_cnt > 0) sres_cnt--;
        end
        i_frame_req = 1'b0;
        i_sys_res = 1'b1;
        repeat (150) @(negedge i_clk);
        chk("frame_count", 32'(dut_done_cnt), 32'(total_frames));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
